seq_gen: RTL and testbench

Parametrised, free-running state-sequence generator. It generalises the fixed 3-flip-flop sequence machine to WIDTH bits with four selectable sequence modes, enable, parallel load and a wrap pulse. It drives the sequence-state bus, plus a decoded output y that is the OR of the two most significant state bits. It sits as a leaf sequencer that feeds pattern/timing logic.

---
 rtl/seq_gen.sv | 126 ++++++++++++
 tb/tb_seq_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- parametrised free-running state-sequence generator
//
// Steps a WIDTH-bit state register through one of four sequences, chosen by
// mode: binary up, Gray, Johnson, or an XNOR Fibonacci LFSR. The register can
// be parallel-loaded, held, or stepped. A one-cycle wrap pulse marks the
// sequence coming back to its start value.
//
// Optional build macro: SEQ_GEN_DIR_EN
//   When defined, this adds a dir input. dir=0 makes the binary and Gray
//   modes count down. Without the macro, counting is up only.
//
// Parameters:
//   WIDTH      state width in bits (3..16)
//   LFSR_TAPS  feedback tap mask for LFSR mode (WIDTH bits)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   en        in   advance the sequence one step per cycle while high
//   load      in   parallel load of load_val (takes priority over en)
//   load_val  in   [WIDTH-1:0] value to load
//   mode      in   [1:0] 00 binary, 01 Gray, 10 Johnson, 11 LFSR
//   dir       in   (SEQ_GEN_DIR_EN only) 1 = up, 0 = down in modes 00/01
//   state     out  [WIDTH-1:0] current sequence value (mode-encoded)
//   y         out  state[WIDTH-1] | state[WIDTH-2]
//   wrap      out  one-cycle pulse after the sequence returns to its start
// -----------------------------------------------------------------------------
module seq_gen #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(4'b1100)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
`ifdef SEQ_GEN_DIR_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] state,
   output logic             y,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] s_p0;
   logic             wrap_p0;
   logic [WIDTH-1:0] s_nxt;
   logic             wrap_nxt;
   logic [WIDTH-1:0] step_val;
   logic             step_wrap;
   logic             up;

`ifdef SEQ_GEN_DIR_EN
   assign up = dir;
`else
   assign up = 1'b1;
`endif

   // Johnson step: shift left and feed back the inverted MSB. Illegal codes
   // are not corrected; they just keep shifting.
   function automatic logic [WIDTH-1:0] johnson_next(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ~v[WIDTH-1]};
   endfunction

   // XNOR Fibonacci LFSR step. All-ones is the XNOR lockup state, so it is
   // forced to zero, which puts the register back on the main cycle.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
      if (v == ALL_ONES)
         return '0;
      return {v[WIDTH-2:0], ~^(v & LFSR_TAPS)};
   endfunction

   // Next-value selection. The priority is load > en > hold. Reset is
   // applied in the register process.
   always_comb begin
      step_val  = s_p0;
      step_wrap = 1'b0;
      s_nxt     = s_p0;
      wrap_nxt  = 1'b0;

      unique case (mode)
         2'b00, 2'b01: step_val = up ? (s_p0 + ONE) : (s_p0 - ONE);
         2'b10:        step_val = johnson_next(s_p0);
         default:      step_val = lfsr_next(s_p0);
      endcase

      // Counting down wraps on the step 0 -> all-ones. Every other case wraps
      // when a non-zero value steps to zero.
      if (!mode[1] && !up)
         step_wrap = (s_p0 == '0);
      else
         step_wrap = (step_val == '0) && (s_p0 != '0);

      if (load) begin
         // Loading the LFSR lockup value would leave the register stuck
         // there, so zero is loaded instead.
         s_nxt = ((mode == 2'b11) && (load_val == ALL_ONES)) ? '0 : load_val;
      end else if (en) begin
         s_nxt    = step_val;
         wrap_nxt = step_wrap;
      end
   end

   // ---- stage p0: state and wrap registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         s_p0    <= '0;
         wrap_p0 <= 1'b0;
      end else begin
         s_p0    <= s_nxt;
         wrap_p0 <= wrap_nxt;
      end
   end

   // The Gray code is decoded from the binary count with no added latency.
   // A mode change reinterprets the stored value at once.
   assign state = (mode == 2'b01) ? (s_p0 ^ (s_p0 >> 1)) : s_p0;
   assign y     = state[WIDTH-1] | state[WIDTH-2];
   assign wrap  = wrap_p0;

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;
   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;
   localparam int TAPS = 4'b1100;

   logic         clk = 1'b0;
   logic         reset, en, load;
   logic [W-1:0] load_val;
   logic [1:0]   mode;
   logic [W-1:0] state;
   logic         y, wrap;
`ifdef SEQ_GEN_DIR_EN
   logic         dir = 1'b1;
`endif

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_s    = 0;
   int m_wrap = 0;

   always #5 clk = ~clk;

   seq_gen #(.WIDTH(W), .LFSR_TAPS(4'b1100)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
`ifdef SEQ_GEN_DIR_EN
      .dir      (dir),
`endif
      .state    (state),
      .y        (y),
      .wrap     (wrap)
   );

   function automatic int ref_next(int s, int md, int d);
      int ones;
      case (md)
         0, 1: return d ? ((s + 1) % (MASK + 1)) : ((s + MASK) % (MASK + 1));
         2:    return ((s * 2) & MASK) + (((s >> (W - 1)) & 1) ? 0 : 1);
         default: begin
            if (s == MASK) return 0;
            ones = 0;
            for (int b = 0; b < W; b++) ones += ((s & TAPS) >> b) & 1;
            return ((s * 2) & MASK) + ((ones % 2 == 0) ? 1 : 0);
         end
      endcase
   endfunction

   function automatic int ref_state();
      return (mode == 2'b01) ? (m_s ^ (m_s >> 1)) : m_s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock, update the model, then check all outputs.
   task automatic cycle();
      int d, nxt;
      int es;
      @(posedge clk);
      d = 1;
`ifdef SEQ_GEN_DIR_EN
      d = dir;
`endif
      if (reset) begin
         m_s = 0; m_wrap = 0;
      end else if (load) begin
         m_s = (mode == 2'b11 && load_val == MASK) ? 0 : int'(load_val);
         m_wrap = 0;
      end else if (en) begin
         nxt = ref_next(m_s, int'(mode), d);
         if (mode < 2 && d == 0) m_wrap = (m_s == 0);
         else                    m_wrap = (nxt == 0 && m_s != 0);
         m_s = nxt;
      end else begin
         m_wrap = 0;
      end
      #1;
      es = ref_state();
      chk("state", state, es);
      chk("y", y, (es >= (1 << (W - 2))) ? 1 : 0);
      chk("wrap", wrap, m_wrap);
   endtask

   initial begin
      logic [W-1:0] prev;
      int johnson_tbl [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
      int gray_tbl    [4] = '{1, 3, 2, 6};
      int lfsr_tbl    [4] = '{1, 3, 7, 14};

      // Reset dominates load and en
      reset = 1; en = 1; load = 1; load_val = 4'hA; mode = 2'b00;
      repeat (2) cycle();
      chk("reset_state", state, 0);
      chk("reset_y", y, 0);
      chk("reset_wrap", wrap, 0);

      // Hold after reset
      reset = 0; en = 0; load = 0;
      repeat (3) cycle();
      chk("hold_zero", state, 0);

      // Binary count through a full period
      en = 1; mode = 2'b00;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         chk("bin_seq", state, i % 16);
         chk("bin_wrap", wrap, (i == 16) ? 1 : 0);
      end

      // Gray: fixed first codes, then one bit changes per step
      mode = 2'b01;
      prev = state;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (i < 4) chk("gray_seq", state, gray_tbl[i]);
         chk("gray_1bit", $countones(state ^ prev), 1);
         prev = state;
      end
      chk("gray_back0", state, 0);

      // Johnson period 8
      mode = 2'b10;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("john_seq", state, johnson_tbl[i]);
         chk("john_wrap", wrap, (i == 7) ? 1 : 0);
      end

      // LFSR period 15
      mode = 2'b11;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (i < 4) chk("lfsr_seq", state, lfsr_tbl[i]);
         chk("lfsr_wrap", wrap, (i == 14) ? 1 : 0);
      end
      chk("lfsr_back0", state, 0);

      // Loading the lockup value in LFSR mode gives zero
      load = 1; en = 1; load_val = 4'hF;
      cycle();
      chk("lfsr_lockload", state, 0);
      chk("lfsr_lockload_wrap", wrap, 0);

      // All-ones loaded in binary mode, then an LFSR step escapes to zero
      mode = 2'b00; load = 1; en = 0; load_val = 4'hF;
      cycle();
      chk("load_ones", state, 15);
      mode = 2'b11; load = 0; en = 1;
      cycle();
      chk("lfsr_escape", state, 0);
      chk("lfsr_escape_wrap", wrap, 1);

      // Load wins over en
      mode = 2'b00; load = 1; en = 0; load_val = 4'd5;
      cycle();
      load = 1; en = 1; load_val = 4'd9;
      cycle();
      chk("load_prio", state, 9);
      load = 0;
      cycle();
      chk("after_load", state, 10);

      // Reset in the middle of a sequence
      reset = 1;
      cycle();
      chk("mid_reset", state, 0);
      reset = 0;

`ifdef SEQ_GEN_DIR_EN
      // Down count from zero wraps to all-ones
      dir = 0; mode = 2'b00; en = 1;
      cycle();
      chk("down_state", state, 15);
      chk("down_wrap", wrap, 1);
      dir = 1;
`endif

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom % 32) == 0;
         load     = ($urandom % 8) == 0;
         en       = ($urandom % 4) != 0;
         load_val = W'($urandom);
         if (($urandom % 16) == 0) mode = 2'($urandom);
`ifdef SEQ_GEN_DIR_EN
         dir = 1'($urandom);
`endif
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
